// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and default constants for the data-memory arbiter.
package data_mem_arbiter_pkg;

  localparam int unsigned DEFAULT_DATA_W     = 32;
  localparam int unsigned DEFAULT_STARVE_MAX = 4;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_PEND = 1'b1
  } rd_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter of consecutive denied DMA cycles; clear wins over increment.
module arb_starve_counter #(
  parameter int unsigned MAX   = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic sat;

  assign sat = (cnt == CNT_W'(MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter: CPU priority with DMA anti-starvation,
// combinational grants and one-cycle read-return tracking.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned STARVE_MAX = DEFAULT_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
  logic             dma_wins;
  logic             rd_gnt;
  rd_state_t        state_q, state_d;
  owner_t           owner_q, owner_d;

  arb_starve_counter #(
    .MAX   (STARVE_MAX),
    .CNT_W (CNT_W)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (dma_req & ~dma_gnt),
    .clr   (dma_gnt),
    .cnt   (starve_cnt)
  );

  // CPU has priority unless the DMA has been denied STARVE_MAX times in a row.
  assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));
  assign dma_wins   = dma_req & (~cpu_req | starve_hit);
  assign dma_gnt    = dma_wins;
  assign cpu_gnt    = cpu_req & ~dma_wins;
  assign mem_en     = cpu_gnt | dma_gnt;
  assign rd_gnt     = mem_en & ~mem_we;
  assign rdata      = mem_rdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RD_IDLE;
      owner_q <= OWN_CPU;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Read-return tracker: a granted read is answered on the following cycle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      RD_IDLE: begin
        if (rd_gnt) begin
          state_d = RD_PEND;
          owner_d = dma_gnt ? OWN_DMA : OWN_CPU;
        end
      end
      RD_PEND: begin
        if (rd_gnt) begin
          state_d = RD_PEND;
          owner_d = dma_gnt ? OWN_DMA : OWN_CPU;
        end else begin
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // A read still pending while reset is held is dropped without a response.
  assign cpu_rvalid = ~reset & (state_q == RD_PEND) & (owner_q == OWN_CPU);
  assign dma_rvalid = ~reset & (state_q == RD_PEND) & (owner_q == OWN_DMA);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model.
module tb_data_mem_arbiter;

  localparam int unsigned DW   = 32;
  localparam int          SMAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [DW-1:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [DW-1:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic          mem_en, mem_we;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] rd_val;
  int            m_starve = 0;
  int            m_pend   = 0;  // 0 none, 1 CPU read outstanding, 2 DMA read outstanding
  bit            started  = 1'b0;

  data_mem_arbiter #(.DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model and per-cycle compare.
  always @(negedge clk) begin
    logic e_cg, e_dg;
    logic [DW-1:0] e_addr, e_wdata;
    logic e_we;
    e_dg = dma_req && (!cpu_req || m_starve == SMAX);
    e_cg = cpu_req && !e_dg;
    e_we    = e_cg ? cpu_we    : e_dg ? dma_we    : 1'b0;
    e_addr  = e_cg ? cpu_addr  : e_dg ? dma_addr  : '0;
    e_wdata = e_cg ? cpu_wdata : e_dg ? dma_wdata : '0;
    if (started) begin
      chk("m_cpu_gnt",    DW'(cpu_gnt),    DW'(e_cg));
      chk("m_dma_gnt",    DW'(dma_gnt),    DW'(e_dg));
      chk("m_mem_en",     DW'(mem_en),     DW'(e_cg | e_dg));
      chk("m_mem_we",     DW'(mem_we),     DW'(e_we));
      chk("m_mem_addr",   mem_addr,        e_addr);
      chk("m_mem_wdata",  mem_wdata,       e_wdata);
      chk("m_cpu_rvalid", DW'(cpu_rvalid), DW'(!reset && m_pend == 1));
      chk("m_dma_rvalid", DW'(dma_rvalid), DW'(!reset && m_pend == 2));
      chk("m_rdata",      rdata,           mem_rdata);
    end
    if (reset) begin
      m_starve = 0;
      m_pend   = 0;
      started  = 1'b1;
    end else begin
      if (e_dg) m_starve = 0;
      else if (dma_req && m_starve < SMAX) m_starve++;
      m_pend = (e_cg && !cpu_we) ? 1 : (e_dg && !dma_we) ? 2 : 0;
    end
  end

  // Apply one cycle of stimulus just after the rising edge, return at the falling edge.
  task automatic cyc(input logic r,
                     input logic cr, input logic cw, input logic [DW-1:0] ca, input logic [DW-1:0] cd,
                     input logic dr, input logic dw, input logic [DW-1:0] da, input logic [DW-1:0] dd);
    @(posedge clk);
    #1;
    reset = r;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    mem_rdata = rd_val;
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    cyc(r, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  logic exp_dgnt [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    rd_val = '0; mem_rdata = '0;
    idle(1'b1);
    idle(1'b1);

    // No requests: everything quiet.
    idle(1'b0);
    chk("idle_mem_en", DW'(mem_en), '0);
    chk("idle_gnts",   DW'({cpu_gnt, dma_gnt}), '0);
    chk("idle_rvalid", DW'({cpu_rvalid, dma_rvalid}), '0);

    // CPU load at 0x60, result returned next cycle.
    cyc(1'b0, 1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 1'b0, '0, '0);
    chk("ld_cpu_gnt",  DW'(cpu_gnt), 32'd1);
    chk("ld_mem_addr", mem_addr, 32'h60);
    rd_val = 32'hDEADBEEF;
    idle(1'b0);
    chk("ld_cpu_rvalid", DW'(cpu_rvalid), 32'd1);
    chk("ld_rdata",      rdata, 32'hDEADBEEF);

    // DMA store 7 to 0x64, no read response afterwards.
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h64, 32'd7);
    chk("st_dma_gnt",   DW'(dma_gnt), 32'd1);
    chk("st_mem_we",    DW'(mem_we), 32'd1);
    chk("st_mem_addr",  mem_addr, 32'h64);
    chk("st_mem_wdata", mem_wdata, 32'd7);
    idle(1'b0);
    chk("st_no_rvalid", DW'({cpu_rvalid, dma_rvalid}), '0);

    // Continuous contention: CPU x4, DMA on the 5th, CPU again.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h100 + DW'(i), '0, 1'b1, 1'b0, 32'h200 + DW'(i), '0);
      chk("starve_dma_gnt", DW'(dma_gnt), DW'(exp_dgnt[i]));
      chk("starve_cpu_gnt", DW'(cpu_gnt), DW'(!exp_dgnt[i]));
    end

    // Alternating CPU read then DMA read.
    cyc(1'b0, 1'b1, 1'b0, 32'h10, '0, 1'b0, 1'b0, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h20, '0);
    chk("alt_dma_gnt",   DW'(dma_gnt), 32'd1);
    chk("alt_rv_n1",     DW'({cpu_rvalid, dma_rvalid}), 32'b10);
    idle(1'b0);
    chk("alt_rv_n2",     DW'({cpu_rvalid, dma_rvalid}), 32'b01);

    // Build starvation up to the limit, then reset with a CPU read pending.
    for (int i = 0; i < SMAX; i++)
      cyc(1'b0, 1'b1, 1'b1, 32'h300, 32'h1, 1'b1, 1'b1, 32'h400, 32'h2);
    cyc(1'b0, 1'b1, 1'b0, 32'h44, '0, 1'b0, 1'b0, '0, '0);
    chk("rst_rd_gnt", DW'(cpu_gnt), 32'd1);
    idle(1'b1);
    chk("rst_rv_drop", DW'({cpu_rvalid, dma_rvalid}), '0);
    idle(1'b0);
    chk("rst_rv_after", DW'({cpu_rvalid, dma_rvalid}), '0);
    cyc(1'b0, 1'b1, 1'b0, 32'h48, '0, 1'b1, 1'b0, 32'h4C, '0);
    chk("rst_starve_clr", DW'(cpu_gnt), 32'd1);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      rd_val = $urandom;
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom,
          $urandom_range(0, 2) != 0, 1'($urandom), $urandom, $urandom);
    end
    idle(1'b0);

    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of data and address buses.
REQ-002 Parameter STARVE_MAX, default 4, consecutive denied DMA cycles before DMA takes priority.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU data-port access request (load or store) this cycle.
REQ-006 cpu_we  input  1  CPU store when high, load when low.
REQ-007 cpu_addr  input  DATA_W  CPU byte address.
REQ-008 cpu_wdata  input  DATA_W  CPU store data.
REQ-009 cpu_gnt  output  1  CPU access accepted this cycle; low means the CPU shall hold its PC and stall.
REQ-010 cpu_rvalid  output  1  rdata carries CPU load result.
REQ-011 dma_req  input  1  DMA/loader access request.
REQ-012 dma_we  input  1  DMA write when high.
REQ-013 dma_addr  input  DATA_W  DMA byte address.
REQ-014 dma_wdata  input  DATA_W  DMA write data.
REQ-015 dma_gnt  output  1  DMA access accepted this cycle.
REQ-016 dma_rvalid  output  1  rdata carries DMA read result.
REQ-017 rdata  output  DATA_W  read data returned to the current rvalid owner, driven directly from mem_rdata.
REQ-018 mem_en  output  1  memory access strobe.
REQ-019 mem_we  output  1  memory write enable.
REQ-020 mem_addr  output  DATA_W  memory address.
REQ-021 mem_wdata  output  DATA_W  memory write data.
REQ-022 mem_rdata  input  DATA_W  memory read data, valid one cycle after a read strobe.

Function
REQ-023 Grants SHALL be combinational from req inputs and registered state; at most one of cpu_gnt/dma_gnt high per cycle.
REQ-024 Only the CPU requesting: cpu_gnt=1. Only the DMA requesting: dma_gnt=1. Neither requesting: both grants=0, mem_en=0.
REQ-025 Both requesting: the CPU wins unless starve_cnt==STARVE_MAX, in which case the DMA wins.
REQ-026 starve_cnt SHALL increment (saturating at STARVE_MAX) each cycle dma_req=1 and dma_gnt=0, clear to 0 on dma_gnt=1, and hold when dma_req=0.
REQ-027 mem_en SHALL equal cpu_gnt|dma_gnt; mem_we/addr/wdata SHALL mux from the granted requester in the same cycle; when idle, mem_we=0 and addr/wdata=0.
REQ-028 A granted read SHALL assert the owner's rvalid exactly one cycle later (1-cycle latency); writes SHALL produce no rvalid.
REQ-029 Read tracking SHALL use a 2-state FSM plus owner bit: RD_IDLE->RD_PEND on a granted read; RD_PEND->RD_PEND on a back-to-back granted read (owner updated); RD_PEND->RD_IDLE otherwise.
REQ-030 cpu_rvalid and dma_rvalid SHALL never be high in the same cycle.
REQ-031 Back-to-back grants to alternating requesters SHALL be allowed with no bubble cycle.

Reset
REQ-032 While reset=1 at a clock edge: starve_cnt=0, FSM=RD_IDLE, and both rvalids are low on the next cycle; a read pending at reset SHALL be dropped without an rvalid.
REQ-033 Grants SHALL remain combinational during reset; memory writes during reset are permitted.

Structure
REQ-034 A shared package SHALL hold the rd_state_t enum {RD_IDLE, RD_PEND}, the requester enum {OWN_CPU, OWN_DMA}, and the default constants.
REQ-035 The block SHALL have one natural sub-module, arb_starve_counter (saturating counter with inc/clr), instantiated once.

Verification
REQ-036 cpu_req=1 only, load at addr 0x60 -> cpu_gnt=1 same cycle, mem_addr=0x60, cpu_rvalid=1 next cycle with rdata=mem_rdata.
REQ-037 Both requesting continuously, STARVE_MAX=4 -> CPU is granted 4 cycles, DMA on the 5th, then the CPU again; starve_cnt returns to 0.
REQ-038 DMA store 7 to 0x64 with cpu_req=0 -> dma_gnt=1, mem_we=1, mem_addr=0x64, mem_wdata=7, no rvalid next cycle.
REQ-039 Alternating CPU read then DMA read on consecutive cycles -> cpu_rvalid in cycle n+1 and dma_rvalid in cycle n+2, never overlapping.
REQ-040 Reset asserted the cycle after a granted read -> no rvalid, starve_cnt=0.
REQ-041 No requests -> mem_en=0, both gnt=0, both rvalid=0.
